// File: rtl/tree_adder_checker.sv
`default_nettype none
// ============================================================================
// tree_adder_checker : LFSR stimulus generator and checker for a 4-input
//                      tree adder (a+b, c+d, total). Rev 1.0
// ============================================================================
module tree_adder_checker #(
   parameter logic [23:0] SEED          = 24'h201482,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] num_vec,
   output logic [3:0]  op_a,
   output logic [3:0]  op_b,
   output logic [7:0]  op_c,
   output logic [7:0]  op_d,
   input  logic [4:0]  dut_sum1,
   input  logic [8:0]  dut_sum2,
   input  logic [9:0]  dut_sum,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_fail_idx,
   output logic [15:0] vec_count
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [23:0] c_SEED_INIT   = (SEED == 24'd0) ? 24'd1 : SEED;
   localparam logic [3:0]  c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [23:0] lfsr_q, lfsr_d;
   logic [3:0]  op_a_q, op_a_d, op_b_q, op_b_d;
   logic [7:0]  op_c_q, op_c_d, op_d_q, op_d_d;
   logic [3:0]  settle_q, settle_d;
   logic [15:0] num_vec_q, num_vec_d;
   logic [15:0] err_q, err_d;
   logic [15:0] first_q, first_d;
   logic [15:0] vcnt_q, vcnt_d;

   logic        w_feedback;
   logic [4:0]  w_exp1;
   logic [8:0]  w_exp2;
   logic [9:0]  w_exp;
   logic        w_mismatch;

   assign w_feedback = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];
   assign w_exp1     = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign w_exp2     = {1'b0, op_c_q} + {1'b0, op_d_q};
   assign w_exp      = {5'd0, w_exp1} + {1'b0, w_exp2};
   assign w_mismatch = (dut_sum1 != w_exp1) || (dut_sum2 != w_exp2) || (dut_sum != w_exp);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lfsr_q    <= c_SEED_INIT;
         op_a_q    <= 4'd0;
         op_b_q    <= 4'd0;
         op_c_q    <= 8'd0;
         op_d_q    <= 8'd0;
         settle_q  <= 4'd0;
         num_vec_q <= 16'd0;
         err_q     <= 16'd0;
         first_q   <= 16'hFFFF;
         vcnt_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         op_c_q    <= op_c_d;
         op_d_q    <= op_d_d;
         settle_q  <= settle_d;
         num_vec_q <= num_vec_d;
         err_q     <= err_d;
         first_q   <= first_d;
         vcnt_q    <= vcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      op_c_d    = op_c_q;
      op_d_d    = op_d_q;
      settle_d  = settle_q;
      num_vec_d = num_vec_q;
      err_d     = err_q;
      first_d   = first_q;
      vcnt_d    = vcnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               lfsr_d    = c_SEED_INIT;
               err_d     = 16'd0;
               vcnt_d    = 16'd0;
               first_d   = 16'hFFFF;
               num_vec_d = num_vec;
               state_d   = (num_vec == 16'd0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            op_a_d   = lfsr_q[3:0];
            op_b_d   = lfsr_q[7:4];
            op_c_d   = lfsr_q[15:8];
            op_d_d   = lfsr_q[23:16];
            lfsr_d   = {lfsr_q[22:0], w_feedback};
            settle_d = 4'd0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            settle_d = settle_q + 4'd1;
            if (settle_q == c_SETTLE_LAST) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (w_mismatch) begin
               if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (err_q == 16'd0)    first_d = vcnt_q;
            end
            vcnt_d  = vcnt_q + 16'd1;
            state_d = (vcnt_q + 16'd1 == num_vec_q) ? S_DONE : S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign op_a           = op_a_q;
   assign op_b           = op_b_q;
   assign op_c           = op_c_q;
   assign op_d           = op_d_q;
   assign busy           = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign done           = (state_q == S_DONE);
   assign pass           = done && (err_q == 16'd0);
   assign err_count      = err_q;
   assign first_fail_idx = first_q;
   assign vec_count      = vcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_adder_checker.sv
`default_nettype none
// ============================================================================
// tb_tree_adder_checker : directed bench with a run-level reference model and
//                         a fault-injecting adder stub. Rev 1.0
// ============================================================================
module tb_tree_adder_checker;
   localparam logic [23:0] SEED   = 24'h201482;
   localparam int          SETTLE = 1;
   localparam int          P      = SETTLE + 2;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [15:0] num_vec = 16'd0;
   logic [3:0]  op_a, op_b;
   logic [7:0]  op_c, op_d;
   logic [4:0]  dut_sum1;
   logic [8:0]  dut_sum2;
   logic [9:0]  dut_sum;
   logic        busy, done, pass;
   logic [15:0] err_count, first_fail_idx, vec_count;

   int fault_mode = 0;   // 0 correct, 1 sum^1 on one vector, 2 sum2 stuck at 0
   int fault_idx  = 0;
   int n_checks   = 0;
   int n_fail     = 0;
   bit chk_en     = 1'b0;

   always #5 clk = ~clk;

   tree_adder_checker #(.SEED(SEED), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
      .dut_sum1(dut_sum1), .dut_sum2(dut_sum2), .dut_sum(dut_sum),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail_idx(first_fail_idx), .vec_count(vec_count)
   );

   // Adder under test, with optional injected faults
   always_comb begin
      logic [4:0] t1;
      logic [8:0] t2;
      t1       = 5'(op_a) + 5'(op_b);
      t2       = 9'(op_c) + 9'(op_d);
      dut_sum1 = t1;
      dut_sum2 = (fault_mode == 2) ? 9'd0 : t2;
      dut_sum  = 10'(t1) + 10'(t2);
      if (fault_mode == 1 && int'(vec_count) == fault_idx) dut_sum = dut_sum ^ 10'd1;
   end

   // Reference model: run-level view (vector list + elapsed clocks since start)
   bit         m_started = 1'b0;
   int         m_o = 0;
   int         m_n = 0;
   logic [3:0] m_pa = '0, m_pb = '0;
   logic [7:0] m_pc = '0, m_pd = '0;
   logic [3:0] va [1024];
   logic [3:0] vb [1024];
   logic [7:0] vcc[1024];
   logic [7:0] vd [1024];
   bit         vbad[1024];

   function automatic logic [23:0] lfsr_next(input logic [23:0] l);
      return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
   endfunction

   function automatic int exp_vc();
      if (!m_started) return 0;
      return (m_o / P < m_n) ? m_o / P : m_n;
   endfunction

   function automatic int exp_err();
      int e = 0;
      for (int k = 0; k < exp_vc() && k < 1024; k++) if (vbad[k]) e++;
      return e;
   endfunction

   function automatic int exp_first();
      for (int k = 0; k < exp_vc() && k < 1024; k++) if (vbad[k]) return k;
      return 16'hFFFF;
   endfunction

   function automatic bit exp_busy();
      return m_started && (m_o < P * m_n);
   endfunction

   function automatic int exp_idx();
      if (!m_started || m_o == 0 || m_n == 0) return -1;
      return ((m_o - 1) / P < m_n) ? (m_o - 1) / P : m_n - 1;
   endfunction

   always @(posedge clk) begin
      int idx;
      logic [23:0] l;
      if (rst) begin
         m_started = 1'b0; m_o = 0; m_n = 0;
         m_pa = '0; m_pb = '0; m_pc = '0; m_pd = '0;
      end else if (start && !exp_busy()) begin
         idx = exp_idx();
         if (idx >= 0) begin
            m_pa = va[idx]; m_pb = vb[idx]; m_pc = vcc[idx]; m_pd = vd[idx];
         end
         m_n = int'(num_vec); m_o = 0; m_started = 1'b1;
         l = SEED;
         for (int k = 0; k < m_n && k < 1024; k++) begin
            va[k] = l[3:0]; vb[k] = l[7:4]; vcc[k] = l[15:8]; vd[k] = l[23:16];
            case (fault_mode)
               1:       vbad[k] = (k == fault_idx);
               2:       vbad[k] = (9'(l[15:8]) + 9'(l[23:16])) != 9'd0;
               default: vbad[k] = 1'b0;
            endcase
            l = lfsr_next(l);
         end
      end else if (m_started && m_o < 1000000) begin
         m_o++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int idx;
         idx = exp_idx();
         check("m_busy", 32'(busy), 32'(exp_busy()));
         check("m_done", 32'(done), 32'(m_started && !exp_busy()));
         check("m_pass", 32'(pass), 32'(m_started && !exp_busy() && exp_err() == 0));
         check("m_vec_count", 32'(vec_count), 32'(exp_vc()));
         check("m_err_count", 32'(err_count), 32'(exp_err()));
         check("m_first_fail", 32'(first_fail_idx), 32'(exp_first()));
         check("m_op_a", 32'(op_a), 32'((idx < 0) ? m_pa : va[idx]));
         check("m_op_b", 32'(op_b), 32'((idx < 0) ? m_pb : vb[idx]));
         check("m_op_c", 32'(op_c), 32'((idx < 0) ? m_pc : vcc[idx]));
         check("m_op_d", 32'(op_d), 32'((idx < 0) ? m_pd : vd[idx]));
      end
   end

   task automatic run(input int n, input int mode, input int fidx);
      int cyc;
      fault_mode = mode; fault_idx = fidx;
      num_vec = 16'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < P * n + 10) begin
         @(negedge clk);
         cyc++;
      end
      check("run_done_timeout", 32'(done), 32'd1);
   endtask

   task automatic check_ops_seed(input string tag);
      check({tag, "_op_a"}, 32'(op_a), 32'd2);
      check({tag, "_op_b"}, 32'(op_b), 32'd8);
      check({tag, "_op_c"}, 32'(op_c), 32'd20);
      check({tag, "_op_d"}, 32'(op_d), 32'd32);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_first_fail", 32'(first_fail_idx), 32'hFFFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;

      // Single vector from SEED, latency pinned by hand
      fault_mode = 0; num_vec = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t1_done_early", 32'(done), 32'd0);
      @(negedge clk);
      check("t1_done_latency", 32'(done), 32'd1);
      check_ops_seed("t1");
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_err", 32'(err_count), 32'd0);
      check("t1_first", 32'(first_fail_idx), 32'hFFFF);

      // Long clean run
      run(1000, 0, 0);
      check("t2_vec_count", 32'(vec_count), 32'd1000);
      check("t2_pass", 32'(pass), 32'd1);

      // Single corrupted total on vector 2
      run(5, 1, 2);
      check("t3_err", 32'(err_count), 32'd1);
      check("t3_first", 32'(first_fail_idx), 32'd2);
      check("t3_pass", 32'(pass), 32'd0);

      // sum2 stuck at zero
      run(4, 2, 0);
      check("t4_err", 32'(err_count), 32'd4);
      check("t4_first", 32'(first_fail_idx), 32'd0);
      check("t4_pass", 32'(pass), 32'd0);

      // Zero-length run
      fault_mode = 0; num_vec = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_pass", 32'(pass), 32'd1);
      check("t5_vec_count", 32'(vec_count), 32'd0);

      // start and num_vec change while busy are ignored
      num_vec = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      num_vec = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40 && !done; c++) @(negedge clk);
      check("t6_done", 32'(done), 32'd1);
      check("t6_vec_count", 32'(vec_count), 32'd5);

      // Reset during WAIT of vector 3, then restart from SEED
      num_vec = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (P * 3 + 1) @(negedge clk);
      check("t7_pre_vec_count", 32'(vec_count), 32'd3);
      check("t7_pre_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t7_rst_busy", 32'(busy), 32'd0);
      check("t7_rst_vec_count", 32'(vec_count), 32'd0);
      check("t7_rst_first", 32'(first_fail_idx), 32'hFFFF);
      check("t7_rst_op_c", 32'(op_c), 32'd0);
      rst = 1'b0;
      run(1, 0, 0);
      check_ops_seed("t7");
      check("t7_pass", 32'(pass), 32'd1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/tree_adder_checker.md
Name: tree_adder_checker

Overview:
Sequential stimulus generator and self-checker that drives the four operands of the combinational four-input tree adder and verifies its three sum outputs. It is the initiator side of the adder interface: it issues LFSR-derived operand sets, waits a programmable settle time, then compares the adder's sum1/sum2/sum against internally recomputed values. It reports a pass/fail verdict, an error count and the first failing vector index, for on-chip or bench self-test.

Parameters:
SEED, 24'h201482, initial LFSR state; a value of 0 is replaced by 24'h000001.
SETTLE_CYCLES, 1, clocks between operand update and result compare; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; starts a run when in IDLE or DONE, ignored otherwise
num_vec  input  16  vectors per run, sampled on an accepted start
op_a  output  4  operand a to the adder
op_b  output  4  operand b to the adder
op_c  output  8  operand c to the adder
op_d  output  8  operand d to the adder
dut_sum1  input  5  adder result a+b
dut_sum2  input  9  adder result c+d
dut_sum  input  10  adder result sum1+sum2
busy  output  1  high in LOAD/WAIT/CHECK
done  output  1  high in DONE
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  16  mismatching vectors, saturates at 16'hFFFF
first_fail_idx  output  16  index of the first mismatching vector; 16'hFFFF if none
vec_count  output  16  vectors checked in the current run

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, op_a..op_d=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF, vec_count=0, lfsr=SEED (or 1 if SEED==0), settle counter=0.
- A reset asserted mid-run aborts the run and restores all reset values on the next edge. No partial verdict is kept.
- LFSR: 24-bit Fibonacci, shifts left each LOAD. new bit = q[23]^q[22]^q[21]^q[16]. Period is maximal; the state is never 0.
- Operand mapping in LOAD: op_a<=lfsr[3:0], op_b<=lfsr[7:4], op_c<=lfsr[15:8], op_d<=lfsr[23:16]. The LFSR advances in the same cycle, so the first vector of a run uses SEED fields.
- Expected values: exp1=op_a+op_b (5b), exp2=op_c+op_d (9b), exp=exp1+exp2 (10b). All are zero-extended and never truncated.
- A vector mismatches if any of the three compares differ.
- FSM states and transitions:
  - IDLE: on start, reload lfsr=SEED, clear err_count/vec_count, set first_fail_idx=FFFF, latch num_vec. If num_vec==0, go to DONE; otherwise go to LOAD.
  - LOAD: register operands and step the LFSR. Clear the settle counter. Go to WAIT.
  - WAIT: increment the settle counter. When the counter reaches SETTLE_CYCLES-1, go to CHECK.
  - CHECK: compare the dut inputs sampled this cycle.
    - On mismatch: err_count++ (saturating). If err_count was 0, first_fail_idx<=vec_count.
    - Always: vec_count++.
    - If vec_count+1==latched num_vec, go to DONE; else go to LOAD.
  - DONE: done=1 and pass=(err_count==0), held until start. Start here behaves as in IDLE (new run, LFSR reseeded).
- Per-vector latency: SETTLE_CYCLES+2 clocks. With N>0, done rises (SETTLE_CYCLES+2)*N+1 clocks after the start edge.
- Operands stay stable from LOAD through CHECK. The dut inputs are not registered before the compare.
- start during busy is ignored. num_vec changes mid-run have no effect.

Test Plan:
- Correct adder model, SEED=24'h201482, num_vec=1, SETTLE_CYCLES=1 -> op_a=2, op_b=8, op_c=20, op_d=32. Adder returns 10/52/62. done is high 4 clocks after start; pass=1, err_count=0, first_fail_idx=FFFF.
- Correct model, num_vec=1000 -> vec_count=1000, pass=1. The 24-bit LFSR never reaches 0 and operands change every vector.
- Fault injection: dut_sum forced to expected^1 only on vector index 2, num_vec=5 -> err_count=1, first_fail_idx=2, pass=0.
- Stuck fault: dut_sum2 tied to 0, num_vec=4 -> err_count=4 (every vector has c+d>0 from SEED), first_fail_idx=0.
- num_vec=0 with start -> DONE on the next clock, pass=1, vec_count=0. A start while busy mid-run leaves the run and counters unaffected.
- rst asserted during WAIT of vector 3 -> next clock: IDLE, all outputs at reset values. A new start reproduces the vector sequence from SEED.
